instruction_fetch_stage: RTL and testbench
==========================================

// Module: instruction_fetch_stage
// PURPOSE
//  Pipeline IF stage that initiates every instruction-memory read. It owns the PC register, drives the
//  combinational-read instruction memory (word index = pc[7:2]), and captures the returned word into the IF/ID
//  pipeline register. It also applies stall/redirect control from downstream stages and halts fetch on an
//  out-of-range PC.
// PARAMETERS
//  RESET_PC   32'd100  byte address loaded into PC on reset (word 25)
//  MEM_WORDS  64       instruction memory depth in words; valid byte range is [0, 4*MEM_WORDS)
//  NOP_INST   32'h0    encoding inserted into IF/ID for bubbles
// PORTS
//  clk            in   1   rising-edge clock
//  rst_n          in   1   asynchronous active-low reset
//  pcOut          out  32  current PC; drives the memory pc input (combinational from the PC register)
//  instIn         in   32  memory read data for pcOut; valid in the same cycle (combinational memory)
//  stall          in   1   hazard unit: hold the PC and IF/ID
//  redirectValid  in   1   branch/jump resolved taken: reload the PC and flush IF/ID
//  redirectTarget in   32  byte target for the redirect
//  ifidInst       out  32  IF/ID instruction
//  ifidPcPlus4    out  32  IF/ID PC+4 of the captured instruction
//  ifidValid      out  1   IF/ID holds a real instruction (0 = bubble)
//  halted         out  1   fetch is in the HALT state
//  faultMisalign  out  1   sticky: a redirect target had [1:0] != 0
//  fetchCount     out  32  number of valid instructions written into IF/ID (wraps at 2^32)
// BEHAVIOUR
//  Reset (async, rst_n=0): PC=RESET_PC, ifidInst=NOP_INST, ifidPcPlus4=0, ifidValid=0, state=RUN,
//   faultMisalign=0, fetchCount=0. Reset applied mid-operation discards all state immediately.
//  inRange = (pcOut < 4*MEM_WORDS), computed combinationally. The PC is always word-aligned.
//  Per rising edge, priority is: redirect > stall > normal.
//  redirectValid=1 (in any state, and regardless of stall):
//   - PC <= {redirectTarget[31:2], 2'b00}.
//   - IF/ID <= bubble (NOP_INST, PcPlus4=0, valid=0).
//   - If redirectTarget[1:0] != 0, set faultMisalign (sticky until reset).
//   - state <= RUN. If the new PC is out of range, the next cycle re-enters HALT through the RUN rule.
//  Otherwise, if stall=1: PC, IF/ID, state and fetchCount all hold.
//  Otherwise, in RUN:
//   - inRange=1: IF/ID <= {instIn, pcOut+4, valid=1}; PC <= pcOut+4; fetchCount++.
//   - inRange=0: IF/ID <= bubble; PC holds; state <= HALT.
//  Otherwise, in HALT: IF/ID <= bubble; PC holds; no count. Only a redirect leaves HALT.
//  halted = (state==HALT). Fetch-to-IF/ID latency is 1 cycle.
//  PC+4 wraps modulo 2^32; it is unreachable in practice because the range check fires first.
// TESTING
//  T1 reset release: first edge -> ifidInst=mem[25], ifidPcPlus4=104, ifidValid=1, pcOut=104, fetchCount=1.
//  T2 free run 5 edges from reset -> IF/ID sequence mem[25..29]; pcOut=120; fetchCount=5.
//  T3 stall held 3 cycles at pcOut=108 -> pcOut, ifidInst and fetchCount unchanged; resumes with mem[27].
//  T4 stall=1 and redirectValid=1 with target=104 on the same edge -> pcOut=104, ifidValid=0,
//   next edge fetches mem[26].
//  T5 redirect target=0x102 -> pcOut=0x100 (out of range), faultMisalign=1; next edge halted=1, ifidValid=0;
//   a later redirect to 100 clears halted.
//  T6 rst_n pulsed low mid-run between clock edges -> outputs return to reset values at once, without a clock edge.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, addresses a combinational instruction memory and fills the IF/ID register.
// Redirects flush and reload the PC, stalls freeze everything, and an out-of-range PC parks fetch in HALT.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'd100,
    parameter int          MEM_WORDS = 64,
    parameter logic [31:0] NOP_INST  = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pcOut,
    input  logic [31:0] instIn,
    input  logic        stall,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    output logic [31:0] ifidInst,
    output logic [31:0] ifidPcPlus4,
    output logic        ifidValid,
    output logic        halted,
    output logic        faultMisalign,
    output logic [31:0] fetchCount
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    localparam logic [32:0] LIMIT = 33'(4 * MEM_WORDS);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  inst_next, pcplus4_next, count_next;
    logic         valid_next, fault_next;
    logic         in_range;
    logic [31:0]  pc_plus4;

    assign pcOut    = pc;
    assign in_range = ({1'b0, pc} < LIMIT);
    assign pc_plus4 = pc + 32'd4;
    assign halted   = (state == HALT);

    // Control priority on each edge: redirect beats stall beats normal fetch.
    // A redirect flushes IF/ID and returns to RUN even while stalled or halted.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        inst_next    = ifidInst;
        pcplus4_next = ifidPcPlus4;
        valid_next   = ifidValid;
        fault_next   = faultMisalign;
        count_next   = fetchCount;

        if (redirectValid) begin
            pc_next      = {redirectTarget[31:2], 2'b00};
            inst_next    = NOP_INST;
            pcplus4_next = 32'd0;
            valid_next   = 1'b0;
            state_next   = RUN;
            if (redirectTarget[1:0] != 2'b00) begin
                fault_next = 1'b1;
            end
        end else if (!stall) begin
            unique case (state)
                RUN: begin
                    if (in_range) begin
                        inst_next    = instIn;
                        pcplus4_next = pc_plus4;
                        valid_next   = 1'b1;
                        pc_next      = pc_plus4;
                        count_next   = fetchCount + 32'd1;
                    end else begin
                        inst_next    = NOP_INST;
                        pcplus4_next = 32'd0;
                        valid_next   = 1'b0;
                        state_next   = HALT;
                    end
                end
                HALT: begin
                    inst_next    = NOP_INST;
                    pcplus4_next = 32'd0;
                    valid_next   = 1'b0;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            pc            <= RESET_PC;
            ifidInst      <= NOP_INST;
            ifidPcPlus4   <= 32'd0;
            ifidValid     <= 1'b0;
            faultMisalign <= 1'b0;
            fetchCount    <= 32'd0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            ifidInst      <= inst_next;
            ifidPcPlus4   <= pcplus4_next;
            ifidValid     <= valid_next;
            faultMisalign <= fault_next;
            fetchCount    <= count_next;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a combinational instruction memory model.
module tb_instruction_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] pcOut;
    logic [31:0] instIn;
    logic        stall;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic [31:0] ifidInst;
    logic [31:0] ifidPcPlus4;
    logic        ifidValid;
    logic        halted;
    logic        faultMisalign;
    logic [31:0] fetchCount;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [64];

    instruction_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pcOut         (pcOut),
        .instIn        (instIn),
        .stall         (stall),
        .redirectValid (redirectValid),
        .redirectTarget(redirectTarget),
        .ifidInst      (ifidInst),
        .ifidPcPlus4   (ifidPcPlus4),
        .ifidValid     (ifidValid),
        .halted        (halted),
        .faultMisalign (faultMisalign),
        .fetchCount    (fetchCount)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instIn = mem[pcOut[7:2]];

    function automatic logic [31:0] word_of(input int k);
        return 32'hC0DE_0000 + 32'(k * 17);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirectValid  = 1'b0;
        redirectTarget = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (pcOut !== 32'd100) begin bad++; $display("FAIL reset_pc got=%0d exp=100", pcOut); end
        total++; if (ifidInst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=0", ifidInst); end
        total++; if (ifidPcPlus4 !== 32'd0) begin bad++; $display("FAIL reset_pc4 got=%0d exp=0", ifidPcPlus4); end
        total++; if (ifidValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ifidValid); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
        total++; if (faultMisalign !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", faultMisalign); end
        total++; if (fetchCount !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fetchCount); end
    endtask

    task automatic test_free_run();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (ifidInst !== word_of(25 + i)) begin bad++; $display("FAIL run_inst[%0d] got=%h exp=%h", i, ifidInst, word_of(25 + i)); end
            total++; if (ifidPcPlus4 !== 32'(104 + 4 * i)) begin bad++; $display("FAIL run_pc4[%0d] got=%0d exp=%0d", i, ifidPcPlus4, 104 + 4 * i); end
            total++; if (ifidValid !== 1'b1) begin bad++; $display("FAIL run_valid[%0d] got=%b exp=1", i, ifidValid); end
            total++; if (pcOut !== 32'(104 + 4 * i)) begin bad++; $display("FAIL run_pc[%0d] got=%0d exp=%0d", i, pcOut, 104 + 4 * i); end
            total++; if (fetchCount !== 32'(i + 1)) begin bad++; $display("FAIL run_count[%0d] got=%0d exp=%0d", i, fetchCount, i + 1); end
        end
        total++; if (pcOut !== 32'd120) begin bad++; $display("FAIL run_final_pc got=%0d exp=120", pcOut); end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (2) step();
        total++; if (pcOut !== 32'd108) begin bad++; $display("FAIL stall_pre_pc got=%0d exp=108", pcOut); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (pcOut !== 32'd108) begin bad++; $display("FAIL stall_pc[%0d] got=%0d exp=108", i, pcOut); end
            total++; if (ifidInst !== word_of(26)) begin bad++; $display("FAIL stall_inst[%0d] got=%h exp=%h", i, ifidInst, word_of(26)); end
            total++; if (fetchCount !== 32'd2) begin bad++; $display("FAIL stall_count[%0d] got=%0d exp=2", i, fetchCount); end
        end
        stall = 1'b0;
        step();
        total++; if (ifidInst !== word_of(27)) begin bad++; $display("FAIL stall_resume_inst got=%h exp=%h", ifidInst, word_of(27)); end
        total++; if (pcOut !== 32'd112) begin bad++; $display("FAIL stall_resume_pc got=%0d exp=112", pcOut); end
        total++; if (fetchCount !== 32'd3) begin bad++; $display("FAIL stall_resume_count got=%0d exp=3", fetchCount); end
    endtask

    task automatic test_stall_redirect();
        do_reset();
        repeat (2) step();
        stall          = 1'b1;
        redirectValid  = 1'b1;
        redirectTarget = 32'd104;
        step();
        stall         = 1'b0;
        redirectValid = 1'b0;
        total++; if (pcOut !== 32'd104) begin bad++; $display("FAIL sr_pc got=%0d exp=104", pcOut); end
        total++; if (ifidValid !== 1'b0) begin bad++; $display("FAIL sr_valid got=%b exp=0", ifidValid); end
        total++; if (ifidInst !== 32'h0) begin bad++; $display("FAIL sr_inst got=%h exp=0", ifidInst); end
        total++; if (fetchCount !== 32'd2) begin bad++; $display("FAIL sr_count got=%0d exp=2", fetchCount); end
        step();
        total++; if (ifidInst !== word_of(26)) begin bad++; $display("FAIL sr_next_inst got=%h exp=%h", ifidInst, word_of(26)); end
        total++; if (ifidPcPlus4 !== 32'd108) begin bad++; $display("FAIL sr_next_pc4 got=%0d exp=108", ifidPcPlus4); end
        total++; if (ifidValid !== 1'b1) begin bad++; $display("FAIL sr_next_valid got=%b exp=1", ifidValid); end
        total++; if (fetchCount !== 32'd3) begin bad++; $display("FAIL sr_next_count got=%0d exp=3", fetchCount); end
    endtask

    task automatic test_misalign_halt();
        do_reset();
        step();
        redirectValid  = 1'b1;
        redirectTarget = 32'h102;
        step();
        redirectValid = 1'b0;
        total++; if (pcOut !== 32'h100) begin bad++; $display("FAIL ma_pc got=%h exp=100", pcOut); end
        total++; if (faultMisalign !== 1'b1) begin bad++; $display("FAIL ma_fault got=%b exp=1", faultMisalign); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL ma_halted_early got=%b exp=0", halted); end
        step();
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL ma_halted got=%b exp=1", halted); end
        total++; if (ifidValid !== 1'b0) begin bad++; $display("FAIL ma_valid got=%b exp=0", ifidValid); end
        step();
        total++; if (pcOut !== 32'h100) begin bad++; $display("FAIL ma_hold_pc got=%h exp=100", pcOut); end
        total++; if (fetchCount !== 32'd1) begin bad++; $display("FAIL ma_hold_count got=%0d exp=1", fetchCount); end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL ma_still_halted got=%b exp=1", halted); end
        redirectValid  = 1'b1;
        redirectTarget = 32'd100;
        step();
        redirectValid = 1'b0;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL ma_unhalt got=%b exp=0", halted); end
        total++; if (pcOut !== 32'd100) begin bad++; $display("FAIL ma_unhalt_pc got=%0d exp=100", pcOut); end
        total++; if (faultMisalign !== 1'b1) begin bad++; $display("FAIL ma_sticky got=%b exp=1", faultMisalign); end
        step();
        total++; if (ifidInst !== word_of(25)) begin bad++; $display("FAIL ma_refetch got=%h exp=%h", ifidInst, word_of(25)); end
        total++; if (fetchCount !== 32'd2) begin bad++; $display("FAIL ma_refetch_count got=%0d exp=2", fetchCount); end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (3) step();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (pcOut !== 32'd100) begin bad++; $display("FAIL ar_pc got=%0d exp=100", pcOut); end
        total++; if (ifidValid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", ifidValid); end
        total++; if (ifidInst !== 32'h0) begin bad++; $display("FAIL ar_inst got=%h exp=0", ifidInst); end
        total++; if (ifidPcPlus4 !== 32'd0) begin bad++; $display("FAIL ar_pc4 got=%0d exp=0", ifidPcPlus4); end
        total++; if (fetchCount !== 32'd0) begin bad++; $display("FAIL ar_count got=%0d exp=0", fetchCount); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        total++; if (ifidInst !== word_of(25)) begin bad++; $display("FAIL ar_after_inst got=%h exp=%h", ifidInst, word_of(25)); end
        total++; if (fetchCount !== 32'd1) begin bad++; $display("FAIL ar_after_count got=%0d exp=1", fetchCount); end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = word_of(k);
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirectValid  = 1'b0;
        redirectTarget = 32'd0;
        test_reset();
        test_free_run();
        test_stall();
        test_stall_redirect();
        test_misalign_halt();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
